// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL lock synchroniser and ordered per-domain reset release
module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP      = 16,
  parameter int NUM_STAGES     = 3,
  parameter int RELOCK_TIMEOUT = 65536,
  parameter int PLL_RST_CYCLES = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  locked_async,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  pll_rst,
  output logic                  all_ready,
  output logic [7:0]            lock_lost_count,
  output logic [2:0]            state_dbg
);

  localparam int REL_SPAN = NUM_STAGES * STAGE_GAP;
  localparam int MAX_A    = (STABLE_CYCLES > RELOCK_TIMEOUT) ? STABLE_CYCLES : RELOCK_TIMEOUT;
  localparam int MAX_B    = (PLL_RST_CYCLES > REL_SPAN) ? PLL_RST_CYCLES : REL_SPAN;
  localparam int MAX_V    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW       = ($clog2(MAX_V + 1) > 17) ? $clog2(MAX_V + 1) : 17;

  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(RELOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] PULSE_LAST   = CW'(PLL_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    PLL_RESET = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  state_t                 state, state_next;
  logic [CW-1:0]          cnt, cnt_next, cnt_inc;
  logic [NUM_STAGES-1:0]  rst_next;
  logic [7:0]             lost_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked_async};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rst_next   = rst_out;
    lost_next  = lock_lost_count;
    cnt_inc    = cnt + CW'(1);
    case (state)
      WAIT_LOCK: begin
        rst_next = '1;
        if (locked_s) begin
          state_next = STABLE;
          cnt_next   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next = PLL_RESET;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      PLL_RESET: begin
        if (cnt == PULSE_LAST) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      STABLE: begin
        // Any low sample restarts the qualification window from scratch.
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_next  = RELEASE;
          cnt_next    = '0;
          rst_next[0] = 1'b0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      RELEASE, RUN: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
          rst_next   = '1;
          if (lock_lost_count != 8'hff) lost_next = lock_lost_count + 8'd1;
        end else if (state == RELEASE) begin
          cnt_next = cnt_inc;
          for (int k = 1; k < NUM_STAGES; k++) begin
            if (cnt_inc == CW'(k * STAGE_GAP)) rst_next[k] = 1'b0;
          end
          // Last bit dropping (or a single-stage chain already clear) completes the release.
          if (rst_next == '0) begin
            state_next = RUN;
            cnt_next   = '0;
          end
        end
      end
      default: begin
        state_next = WAIT_LOCK;
        cnt_next   = '0;
        rst_next   = '1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= WAIT_LOCK;
      cnt             <= '0;
      rst_out         <= '1;
      pll_rst         <= 1'b0;
      all_ready       <= 1'b0;
      lock_lost_count <= 8'd0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      rst_out         <= rst_next;
      pll_rst         <= (state_next == PLL_RESET);
      all_ready       <= (state_next == RUN);
      lock_lost_count <= lost_next;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

  localparam int SC  = 8;
  localparam int GAP = 4;
  localparam int NS  = 3;
  localparam int TO  = 50;
  localparam int PR  = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          locked_async = 1'b0;
  logic [NS-1:0] rst_out;
  logic          pll_rst;
  logic          all_ready;
  logic [7:0]    lock_lost_count;
  logic [2:0]    state_dbg;

  pll_reset_sequencer #(
    .SYNC_STAGES(2), .STABLE_CYCLES(SC), .STAGE_GAP(GAP),
    .NUM_STAGES(NS), .RELOCK_TIMEOUT(TO), .PLL_RST_CYCLES(PR)
  ) dut (
    .clock(clock), .reset(reset), .locked_async(locked_async),
    .rst_out(rst_out), .pll_rst(pll_rst), .all_ready(all_ready),
    .lock_lost_count(lock_lost_count), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [15:0] v;
  } ev_t;

  ev_t  sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mcyc = 0;
  int   rel = 0;
  bit   armed = 1'b0;

  function automatic logic [15:0] pack(input logic [2:0] s, input logic [2:0] r,
                                       input logic p, input logic a, input logic [7:0] c);
    return {s, r, p, a, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, mcyc, act, exp);
    end
  endtask

  // Reference model: phase + time-in-phase; reset mask derived arithmetically.
  int          m_phase = 0;
  int          m_el = 0;
  int          m_lost = 0;
  logic [1:0]  m_sync = 2'b00;
  logic [15:0] m_prev;

  always @(posedge clock) begin : model
    logic        ls;
    logic [15:0] now;
    int          mask;
    mcyc++;
    if (reset) begin
      m_phase = 0; m_el = 0; m_lost = 0; m_sync = 2'b00; rel = 0;
    end else begin
      rel++;
      ls = m_sync[1];
      m_sync = {m_sync[0], locked_async};
      case (m_phase)
        0: if (ls) begin m_phase = 1; m_el = 0; end
           else if (m_el == TO - 1) begin m_phase = 4; m_el = 0; end
           else m_el++;
        4: if (m_el == PR - 1) begin m_phase = 0; m_el = 0; end
           else m_el++;
        1: if (!ls) begin m_phase = 0; m_el = 0; end
           else if (m_el == SC - 1) begin m_phase = 2; m_el = 0; end
           else m_el++;
        default: if (!ls) begin
            m_phase = 0; m_el = 0;
            if (m_lost < 255) m_lost++;
          end else if (m_phase == 2) begin
            m_el++;
            if (m_el >= ((NS > 1) ? (NS - 1) * GAP : 1)) begin m_phase = 3; m_el = 0; end
          end
      endcase
    end
    mask = 0;
    if (m_phase == 0 || m_phase == 1 || m_phase == 4) mask = (1 << NS) - 1;
    else if (m_phase == 2)
      for (int k = 0; k < NS; k++) if (k * GAP > m_el) mask = mask | (1 << k);
    now = pack(3'(m_phase), 3'(mask), m_phase == 4, m_phase == 3, 8'(m_lost));
    if (armed && now != m_prev) sb_q.push_back('{mcyc, now});
    m_prev = now;
  end

  logic [15:0] d_prev;

  always @(negedge clock) begin : monitor
    logic [15:0] cur;
    ev_t         e;
    cur = pack(state_dbg, rst_out, pll_rst, all_ready, lock_lost_count);
    if (armed && cur !== d_prev) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected at cyc %0d: got %h, expected no change", mcyc, cur);
      end else begin
        e = sb_q.pop_front();
        if (e.v !== cur || e.cyc != mcyc) begin
          n_bad++;
          $display("FAIL sb_event: got %h at cyc %0d, expected %h at cyc %0d", cur, mcyc, e.v, e.cyc);
        end
      end
    end
    d_prev = cur;
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    while (rel < n) @(negedge clock);
  endtask

  task automatic wait_state(input logic [2:0] want, input string name);
    int n = 0;
    while (state_dbg !== want && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (state_dbg !== want) check(name, state_dbg, want);
  endtask

  initial begin
    do_reset();
    check("reset_rst_out", rst_out, 7);
    check("reset_pll_rst", pll_rst, 0);
    check("reset_all_ready", all_ready, 0);
    check("reset_lost", lock_lost_count, 0);
    check("reset_state", state_dbg, 0);
    repeat (3) tick();
    armed = 1'b1;

    // Nominal lock, then loss in RUN, relock, then reset mid-RELEASE.
    wait_rel(10); locked_async = 1'b1;
    wait_rel(13); check("t1_stable", state_dbg, 1);
    wait_rel(20); check("t1_rst_20", rst_out, 7);
    wait_rel(21); check("t1_rst_21", rst_out, 6);
    wait_rel(25); check("t1_rst_25", rst_out, 4);
    wait_rel(29); check("t1_rst_29", rst_out, 0);
    check("t1_ready_29", all_ready, 1);
    check("t1_state_29", state_dbg, 3);
    wait_rel(40); locked_async = 1'b0;
    wait_rel(42); check("t3_still_run", state_dbg, 3);
    wait_rel(43); check("t3_rst", rst_out, 7);
    check("t3_ready", all_ready, 0);
    check("t3_state", state_dbg, 0);
    check("t3_lost", lock_lost_count, 1);
    wait_rel(50); locked_async = 1'b1;
    wait_rel(69); check("t3_rerun", state_dbg, 3);
    wait_rel(70); locked_async = 1'b0;
    wait_rel(75); locked_async = 1'b1;
    wait_rel(86); check("t5_release", rst_out, 6);
    check("t5_lost_pre", lock_lost_count, 2);
    reset = 1'b1; locked_async = 1'b0;
    tick(); reset = 1'b0;
    check("t5a_rst", rst_out, 7);
    check("t5a_pll", pll_rst, 0);
    check("t5a_state", state_dbg, 0);
    check("t5a_lost", lock_lost_count, 0);

    // No lock: periodic PLL reset pulses, then reset mid-pulse.
    do_reset();
    wait_rel(49); check("t4_pll_49", pll_rst, 0);
    wait_rel(50); check("t4_pll_50", pll_rst, 1);
    check("t4_state_50", state_dbg, 4);
    wait_rel(54); check("t4_pll_54", pll_rst, 1);
    wait_rel(55); check("t4_pll_55", pll_rst, 0);
    check("t4_state_55", state_dbg, 0);
    wait_rel(104); check("t4_pll_104", pll_rst, 0);
    wait_rel(105); check("t4_pll_105", pll_rst, 1);
    wait_rel(107);
    reset = 1'b1;
    tick(); reset = 1'b0;
    check("t5b_pll", pll_rst, 0);
    check("t5b_state", state_dbg, 0);
    check("t5b_rst", rst_out, 7);

    // One-cycle glitch during STABLE restarts qualification.
    do_reset();
    wait_rel(10); locked_async = 1'b1;
    wait_rel(13); check("t2_stable", state_dbg, 1);
    wait_rel(16); locked_async = 1'b0;
    wait_rel(17); locked_async = 1'b1;
    wait_rel(19); check("t2_back_wait", state_dbg, 0);
    wait_rel(20); check("t2_restable", state_dbg, 1);
    wait_rel(27); check("t2_rst_27", rst_out, 7);
    wait_rel(28); check("t2_rst_28", rst_out, 6);
    check("t2_lost", lock_lost_count, 0);

    // Saturation of the loss counter.
    do_reset();
    for (int i = 0; i < 260; i++) begin
      locked_async = 1'b1;
      wait_state(3, "t6_reach_run");
      locked_async = 1'b0;
      wait_state(0, "t6_reach_wait");
    end
    check("t6_lost_sat", lock_lost_count, 255);

    // Random lock patterns with occasional resets.
    do_reset();
    for (int i = 0; i < 80; i++) begin
      locked_async = ($urandom_range(0, 2) != 0);
      repeat ($urandom_range(1, 70)) tick();
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
    end

    locked_async = 1'b0;
    repeat (5) tick();
    check("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
